// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default constants for the output pulse stretcher.
package pulse_stretcher_pkg;

    // FSM states: idle, output high window, enforced low gap
    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eHIGH = 2'd1,
        eLOW  = 2'd2
    } state_e;

    localparam int DEF_HIGH_CYCLES = 16;
    localparam int DEF_LOW_CYCLES  = 10;
    localparam int DEF_MAX_PENDING = 3;

    // Cycle counter width: enough to count the longer of the two windows, never zero
    function automatic int cnt_width(input int high_cycles, input int low_cycles);
        int m;
        int w;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into a pin-level output with a minimum
// high time and a minimum low gap; events arriving while busy are queued up to
// MAX_PENDING deep, and any beyond that are dropped and flagged.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic data_i,
    output logic data_o,
    output logic busy_o,
    output logic overflow_o
);

    localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          data_q, data_d;
    logic          ovf_q, ovf_d;

    logic          last_low;
    logic          can_start;
    logic          have_pend;
    logic          start;

    // Next-state: window sequencing, start arbitration (queue before data_i), queue accounting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        last_low  = (state_q == eLOW) && (cnt_q == LOW_LAST);
        can_start = (state_q == eIDLE) || last_low;
        have_pend = (pend_q != '0);
        start     = can_start && (have_pend || data_i);

        case (state_q)
            eHIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = eLOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            eLOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d = eIDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            eIDLE: ;
            default: begin
                state_d = eIDLE;
                cnt_d   = '0;
            end
        endcase

        // A start seamlessly chains the next window with no idle cycle in between
        if (start) begin
            state_d = eHIGH;
            cnt_d   = '0;
        end

        // Queue: a start drains one entry first; data_i not consumed by a start is queued or dropped
        if (start && have_pend) begin
            if (!data_i) begin
                pend_d = pend_q - 1'b1;
            end
        end else if (data_i && !start) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        data_d = (state_d == eHIGH);
    end

    // All state and registered outputs; reset wins and clears the queue at once
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            data_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != eIDLE) || (pend_q != '0);

endmodule
